// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and FIPS 180-4 bit functions for the
// single-block SHA-256 compression engine.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] IV_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// Combinational single SHA-256 round: working variables a..h (index 0 = a)
// plus K_t and W_t in, updated a..h out.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [7:0][31:0] work,
    input  logic [31:0]      k,
    input  logic [31:0]      w,
    output logic [7:0][31:0] work_next
);

    logic [31:0] t1_s;
    logic [31:0] t2_s;

    // Round function: temporaries and the a..h rotation
    always_comb begin
        t1_s = work[7] + big_sigma1(work[4]) + ch(work[4], work[5], work[6]) + k + w;
        t2_s = big_sigma0(work[0]) + maj(work[0], work[1], work[2]);
        work_next[0] = t1_s + t2_s;
        work_next[1] = work[0];
        work_next[2] = work[1];
        work_next[3] = work[2];
        work_next[4] = work[3] + t1_s;
        work_next[5] = work[4];
        work_next[6] = work[5];
        work_next[7] = work[6];
    end

endmodule

// File: rtl/sha256_core.sv
// Single-block SHA-256 engine: loads one padded block out of reset, runs 64
// rounds (one per clock) and holds the IV-added digest until the next reset.
module sha256_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [511:0] data,
    output logic [255:0] hash,
    output logic         done
);

    state_e            state_r;
    state_e            state_next_s;
    logic [5:0]        t_r;
    logic [15:0][31:0] w_r;
    logic [7:0][31:0]  work_r;
    logic [7:0][31:0]  work_next_s;
    logic [31:0]       w_new_s;
    logic [255:0]      hash_r;
    logic              done_r;

    // The window always holds W_t..W_t+15, so W_t is element 0 and the
    // word shifted in is W_t+16 = s1(W_t+14) + W_t+9 + s0(W_t+1) + W_t.
    always_comb begin
        w_new_s = small_sigma1(w_r[14]) + w_r[9] + small_sigma0(w_r[1]) + w_r[0];
    end

    sha256_round u_round (
        .work      (work_r),
        .k         (K_TABLE[t_r]),
        .w         (w_r[0]),
        .work_next (work_next_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD:  state_next_s = ST_ROUND;
            ST_ROUND: begin
                if (t_r == 6'd63) begin
                    state_next_s = ST_FINAL;
                end else begin
                    state_next_s = ST_ROUND;
                end
            end
            ST_FINAL: state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_DONE;
            default:  state_next_s = ST_LOAD;
        endcase
    end

    // Datapath: schedule window, working registers, round counter, outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_r    <= 6'd0;
            w_r    <= '0;
            work_r <= '0;
            hash_r <= 256'd0;
            done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    for (int i = 0; i < 16; i++) begin
                        w_r[i] <= data[511 - 32*i -: 32];
                    end
                    for (int i = 0; i < 8; i++) begin
                        work_r[i] <= IV_INIT[i];
                    end
                    t_r <= 6'd0;
                end
                ST_ROUND: begin
                    work_r <= work_next_s;
                    w_r    <= {w_new_s, w_r[15:1]};
                    t_r    <= t_r + 6'd1;
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        hash_r[255 - 32*i -: 32] <= work_r[i] + IV_INIT[i];
                    end
                    done_r <= 1'b1;
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign hash = hash_r;
    assign done = done_r;

endmodule

// File: tb/tb_sha256_core.sv
// Directed self-checking bench for sha256_core: known digests, exact latency,
// hold after completion, asynchronous clear and back-to-back runs.
module tb_sha256_core;

    logic         clk;
    logic         rst_n;
    logic [511:0] data;
    logic [255:0] hash;
    logic         done;

    int checks = 0;
    int errors = 0;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h00000000}}};
    localparam logic [255:0] DIG_ABC   =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    sha256_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .hash  (hash),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reset is low on entry; present the block, release on a falling edge and
    // check every edge up to and including the one that publishes the digest.
    task automatic run_block(input logic [511:0] blk, input logic [255:0] dig, input string tag);
        rst_n = 1'b0;
        data  = blk;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 66; e++) begin
            @(posedge clk);
            #1;
            if (e < 66) begin
                check({tag, "_busy"}, {done, hash}, {1'b0, 256'd0});
            end else begin
                check({tag, "_digest"}, {done, hash}, {1'b1, dig});
            end
        end
    endtask

    initial begin
        logic [511:0] rnd;
        rst_n = 1'b0;
        data  = BLK_ABC;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {done, hash}, {1'b0, 256'd0});

        // abc digest with full latency profile
        run_block(BLK_ABC, DIG_ABC, "abc");

        // digest and done hold while data changes
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) rnd[32*i +: 32] = $urandom;
            data = rnd;
            @(posedge clk);
            #1;
            check("hold", {done, hash}, {1'b1, DIG_ABC});
        end

        // asynchronous clear from the finished state, between clock edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_done", {done, hash}, {1'b0, 256'd0});

        // empty message immediately after abc
        run_block(BLK_EMPTY, DIG_EMPTY, "empty");

        // mid-run reset at round 30 (edge 32 after release)
        rst_n = 1'b0;
        data  = BLK_ABC;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_clear", {done, hash}, {1'b0, 256'd0});
        run_block(BLK_EMPTY, DIG_EMPTY, "empty_after_abort");

        // abc again to show nothing carries over
        run_block(BLK_ABC, DIG_ABC, "abc_again");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
